fifo_wr_framer: RTL and testbench

//  Write-side framer in the clk_w domain, directly upstream of the dual-clock byte FIFO.

---
 rtl/fifo_framer_pkg.sv | 35 +++
 rtl/fifo_wr_framer.sv | 149 ++++++++++++++
 tb/tb_fifo_wr_framer.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_framer_pkg.sv
// Shared constants, state encoding and byte helpers for the write-side FIFO framer.
// Frames on the wire are FLAG, byte-stuffed payload, FLAG.
package fifo_framer_pkg;

  localparam logic [7:0] FLAG_DEF  = 8'h7E;
  localparam logic [7:0] ESC_DEF   = 8'h7D;
  localparam logic [7:0] XMASK_DEF = 8'h20;
  localparam int         CNT_W_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SOF  = 3'd1,
    ST_DATA = 3'd2,
    ST_ESC2 = 3'd3,
    ST_WAIT = 3'd4,
    ST_EOF  = 3'd5
  } state_t;

  // One accepted word; nbytes is already decoded to 1..4.
  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  nbytes;
    logic        last;
  } hold_t;

  function automatic logic needs_esc(input logic [7:0] b, input logic [7:0] flag,
                                     input logic [7:0] esc);
    return (b == flag) || (b == esc);
  endfunction

  function automatic logic [7:0] byte_at(input logic [31:0] w, input logic [1:0] idx);
    return w[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/fifo_wr_framer.sv
// Write-side HDLC-style framer: turns 32-bit words into a byte-stuffed, FLAG-delimited
// byte stream on the FIFO write port, stalling cleanly on buf_full.
module fifo_wr_framer
  import fifo_framer_pkg::*;
#(
  parameter logic [7:0] FLAG  = FLAG_DEF,
  parameter logic [7:0] ESC   = ESC_DEF,
  parameter logic [7:0] XMASK = XMASK_DEF,
  parameter int         CNT_W = CNT_W_DEF
) (
  input  logic             clk_w,
  input  logic             rst,
  input  logic [31:0]      s_data,
  input  logic [1:0]       s_nbytes,
  input  logic             s_last,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             buf_full,
  output logic             wr_en,
  output logic [7:0]       buf_in,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt
);

  state_t           state_q, state_d;
  hold_t            hold_q, hold_d;
  logic [1:0]       idx_q, idx_d;
  logic [7:0]       buf_in_q, buf_in_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  logic             out_vld;
  logic [7:0]       curByte;
  logic             moreBytes;
  state_t           advState;
  logic [1:0]       advIdx;
  logic [7:0]       advBuf;

  // First code presented for a payload byte: the escape prefix or the byte itself.
  function automatic logic [7:0] leadCode(input logic [7:0] b);
    return needs_esc(b, FLAG, ESC) ? ESC : b;
  endfunction

  always_ff @(posedge clk_w or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      idx_q       <= '0;
      buf_in_q    <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      idx_q       <= idx_d;
      buf_in_q    <= buf_in_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    idx_d       = idx_q;
    buf_in_d    = buf_in_q;
    frame_cnt_d = frame_cnt_q;

    curByte   = byte_at(hold_q.data, idx_q);
    moreBytes = ({1'b0, idx_q} + 3'd1) < hold_q.nbytes;

    // Where the FSM goes once the current payload byte has been fully emitted.
    if (moreBytes) begin
      advState = ST_DATA;
      advIdx   = idx_q + 2'd1;
      advBuf   = leadCode(byte_at(hold_q.data, idx_q + 2'd1));
    end else if (hold_q.last) begin
      advState = ST_EOF;
      advIdx   = idx_q;
      advBuf   = FLAG;
    end else begin
      advState = ST_WAIT;
      advIdx   = idx_q;
      advBuf   = buf_in_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (s_valid) begin
          hold_d   = '{data: s_data, nbytes: (s_nbytes == 2'd0) ? 3'd4 : {1'b0, s_nbytes},
                       last: s_last};
          idx_d    = 2'd0;
          state_d  = ST_SOF;
          buf_in_d = FLAG;
        end
      end
      ST_SOF: begin
        if (wr_en) begin
          state_d  = ST_DATA;
          buf_in_d = leadCode(byte_at(hold_q.data, 2'd0));
        end
      end
      ST_DATA: begin
        if (wr_en) begin
          if (needs_esc(curByte, FLAG, ESC)) begin
            state_d  = ST_ESC2;
            buf_in_d = curByte ^ XMASK;
          end else begin
            state_d  = advState;
            idx_d    = advIdx;
            buf_in_d = advBuf;
          end
        end
      end
      ST_ESC2: begin
        if (wr_en) begin
          state_d  = advState;
          idx_d    = advIdx;
          buf_in_d = advBuf;
        end
      end
      ST_WAIT: begin
        if (s_valid) begin
          hold_d   = '{data: s_data, nbytes: (s_nbytes == 2'd0) ? 3'd4 : {1'b0, s_nbytes},
                       last: s_last};
          idx_d    = 2'd0;
          state_d  = ST_DATA;
          buf_in_d = leadCode(s_data[7:0]);
        end
      end
      ST_EOF: begin
        if (wr_en) begin
          frame_cnt_d = frame_cnt_q + CNT_W'(1);
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    out_vld = (state_q == ST_SOF) || (state_q == ST_DATA) ||
              (state_q == ST_ESC2) || (state_q == ST_EOF);
    wr_en   = out_vld & ~buf_full;
    s_ready = (state_q == ST_IDLE) || (state_q == ST_WAIT);
    busy    = (state_q != ST_IDLE);
  end

  assign buf_in    = buf_in_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_fifo_wr_framer.sv
// Self-checking bench for fifo_wr_framer: a byte scoreboard fed from vector tables,
// hand-written stall/gap/reset sequences, a counter-wrap run and a random stall soak.
module tb_fifo_wr_framer;

  localparam int CNT_W = 4;

  logic             clk_w = 1'b0;
  logic             rst;
  logic [31:0]      s_data;
  logic [1:0]       s_nbytes;
  logic             s_last;
  logic             s_valid;
  logic             s_ready;
  logic             buf_full;
  logic             wr_en;
  logic [7:0]       buf_in;
  logic             busy;
  logic [CNT_W-1:0] frame_cnt;

  int         checks = 0;
  int         errors = 0;
  int         expFrames = 0;
  logic [7:0] expQ[$];
  bit         soakOn = 1'b0;
  bit         openFrame = 1'b0;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  nb;
    logic        last;
    int          nExp;
    logic [79:0] exp;
  } vec_t;

  vec_t vecs[6];

  always #5 clk_w = ~clk_w;

  fifo_wr_framer #(.CNT_W(CNT_W)) dut (
    .clk_w    (clk_w),
    .rst      (rst),
    .s_data   (s_data),
    .s_nbytes (s_nbytes),
    .s_last   (s_last),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .buf_full (buf_full),
    .wr_en    (wr_en),
    .buf_in   (buf_in),
    .busy     (busy),
    .frame_cnt(frame_cnt)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: timed out", name);
  endtask

  // Reference encoder: byte stuffing as seen on the FIFO write port.
  task automatic pushEnc(input logic [7:0] b);
    if (b == 8'h7E || b == 8'h7D) begin
      expQ.push_back(8'h7D);
      expQ.push_back(b ^ 8'h20);
    end else begin
      expQ.push_back(b);
    end
  endtask

  task automatic modelWord(input logic [31:0] d, input logic [1:0] nb, input logic last);
    int n;
    n = (nb == 2'd0) ? 4 : int'(nb);
    if (!openFrame) expQ.push_back(8'h7E);
    for (int k = 0; k < n; k++) pushEnc(d[k*8 +: 8]);
    if (last) begin
      expQ.push_back(8'h7E);
      expFrames++;
    end
    openFrame = !last;
  endtask

  task automatic applyStimulus(input logic [31:0] d, input logic [1:0] nb, input logic last);
    bit ok;
    ok = 1'b0;
    s_data   = d;
    s_nbytes = nb;
    s_last   = last;
    s_valid  = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk_w);
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) failNow("word acceptance");
    @(posedge clk_w);
    #1;
    s_valid  = 1'b0;
    s_nbytes = 2'($urandom);
    s_last   = 1'($urandom);
  endtask

  task automatic waitDrain(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_w);
      if (expQ.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) failNow(name);
    @(posedge clk_w);
    #1;
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    @(posedge clk_w);
    #1;
    rst = 1'b0;
    expQ.delete();
    expFrames = 0;
    openFrame = 1'b0;
  endtask

  // Scoreboard: every byte the DUT writes must be the next expected one.
  always @(negedge clk_w) begin
    if (!rst && wr_en) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected byte: got %h, expected no write", buf_in);
      end else begin
        checkOutput("stream byte", {24'd0, buf_in}, {24'd0, expQ.pop_front()});
      end
    end
  end

  always @(posedge clk_w) begin
    if (soakOn) begin
      #1;
      buf_full = ($urandom_range(0, 2) == 0);
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit ok;
    logic [31:0] d;
    logic [1:0]  nb;
    logic        last;

    vecs[0] = '{32'h44332211, 2'd0, 1'b1, 6,  80'h7E_44_33_22_11_7E};
    vecs[1] = '{32'h00007D7E, 2'd2, 1'b1, 6,  80'h7E_5D_7D_5E_7D_7E};
    vecs[2] = '{32'h000000AB, 2'd1, 1'b1, 3,  80'h7E_AB_7E};
    vecs[3] = '{32'h7E7E7E7E, 2'd0, 1'b1, 10, 80'h7E_5E7D_5E7D_5E7D_5E7D_7E};
    vecs[4] = '{32'h5D7D2000, 2'd3, 1'b1, 6,  80'h7E_5D_7D_20_00_7E};
    vecs[5] = '{32'h12345678, 2'd3, 1'b1, 5,  80'h7E_34_56_78_7E};

    rst      = 1'b1;
    s_data   = '0;
    s_nbytes = '0;
    s_last   = 1'b0;
    s_valid  = 1'b0;
    buf_full = 1'b0;
    repeat (2) @(posedge clk_w);
    #1;
    checkOutput("reset s_ready", 32'(s_ready), 32'd1);
    checkOutput("reset wr_en", 32'(wr_en), 32'd0);
    checkOutput("reset buf_in", 32'(buf_in), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset frame_cnt", 32'(frame_cnt), 32'd0);
    rst = 1'b0;
    @(posedge clk_w);
    #1;

    $display("[TB] table vectors");
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < vecs[i].nExp; k++) expQ.push_back(vecs[i].exp[k*8 +: 8]);
      applyStimulus(vecs[i].data, vecs[i].nb, vecs[i].last);
      waitDrain("table drain");
      expFrames++;
      checkOutput("table frame_cnt", 32'(frame_cnt), 32'(expFrames % (1 << CNT_W)));
      checkOutput("table s_ready idle", 32'(s_ready), 32'd1);
    end

    $display("[TB] stall while 0x22 presented");
    modelWord(32'h44332211, 2'd0, 1'b1);
    applyStimulus(32'h44332211, 2'd0, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_w);
      #1;
      if (buf_in == 8'h22) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) failNow("reach byte 0x22");
    buf_full = 1'b1;
    repeat (5) begin
      @(negedge clk_w);
      checkOutput("stall wr_en", 32'(wr_en), 32'd0);
      checkOutput("stall buf_in", 32'(buf_in), 32'h22);
      checkOutput("stall s_ready", 32'(s_ready), 32'd0);
    end
    @(posedge clk_w);
    #1;
    buf_full = 1'b0;
    waitDrain("stall drain");
    checkOutput("stall frame_cnt", 32'(frame_cnt), 32'(expFrames % (1 << CNT_W)));

    $display("[TB] two-word frame with idle gap");
    modelWord(32'h0D0C0B0A, 2'd0, 1'b0);
    applyStimulus(32'h0D0C0B0A, 2'd0, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_w);
      if (s_ready && busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) failNow("reach WAIT");
    checkOutput("gap first word drained", 32'(expQ.size()), 32'd0);
    repeat (3) begin
      @(negedge clk_w);
      checkOutput("gap busy", 32'(busy), 32'd1);
      checkOutput("gap wr_en", 32'(wr_en), 32'd0);
    end
    @(posedge clk_w);
    #1;
    modelWord(32'h000000EE, 2'd1, 1'b1);
    applyStimulus(32'h000000EE, 2'd1, 1'b1);
    waitDrain("gap drain");
    checkOutput("gap frame_cnt", 32'(frame_cnt), 32'(expFrames % (1 << CNT_W)));

    $display("[TB] reset mid-frame");
    expQ.push_back(8'h7E);
    expQ.push_back(8'h11);
    applyStimulus(32'h44332211, 2'd0, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_w);
      #1;
      if (expQ.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) failNow("partial frame");
    rst = 1'b1;
    #1;
    checkOutput("mid reset wr_en", 32'(wr_en), 32'd0);
    checkOutput("mid reset s_ready", 32'(s_ready), 32'd1);
    checkOutput("mid reset frame_cnt", 32'(frame_cnt), 32'd0);
    checkOutput("mid reset busy", 32'(busy), 32'd0);
    @(posedge clk_w);
    #1;
    rst = 1'b0;
    expQ.delete();
    expFrames = 0;
    openFrame = 1'b0;
    modelWord(32'h44332211, 2'd0, 1'b1);
    applyStimulus(32'h44332211, 2'd0, 1'b1);
    waitDrain("post reset drain");
    checkOutput("post reset frame_cnt", 32'(frame_cnt), 32'd1);

    $display("[TB] frame counter wrap");
    pulseReset();
    for (int i = 0; i < (1 << CNT_W) + 1; i++) begin
      d = {24'd0, 8'($urandom)};
      modelWord(d, 2'd1, 1'b1);
      applyStimulus(d, 2'd1, 1'b1);
    end
    waitDrain("wrap drain");
    checkOutput("wrap frame_cnt", 32'(frame_cnt), 32'd1);

    $display("[TB] random stall soak");
    soakOn = 1'b1;
    for (int i = 0; i < 60; i++) begin
      for (int k = 0; k < 4; k++) begin
        case ($urandom_range(0, 3))
          0:       d[k*8 +: 8] = 8'h7E;
          1:       d[k*8 +: 8] = 8'h7D;
          default: d[k*8 +: 8] = 8'($urandom);
        endcase
      end
      nb   = 2'($urandom_range(0, 3));
      last = (i == 59) || ($urandom_range(0, 2) == 0);
      modelWord(d, nb, last);
      applyStimulus(d, nb, last);
    end
    waitDrain("soak drain");
    soakOn = 1'b0;
    @(posedge clk_w);
    #2;
    buf_full = 1'b0;
    checkOutput("soak frame_cnt", 32'(frame_cnt), 32'(expFrames % (1 << CNT_W)));
    checkOutput("soak leftover bytes", 32'(expQ.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
